mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Producer side of operand forwarding: stage-4 [Mem] and stage-5 [Writeback] pipeline registers of the RV32I core.
- Accepts [ALU] results, runs load/store over a req/ack data bus, and formats load data.
- Publishes the rd address, write-enable, valid and data of stages 4 and 5 that the forwarding unit consumes.
- Drives the register-file write port.

Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- alu_en  in  1  [ALU] stage presents a valid instruction
- alu_rd  in  5  destination register
- alu_rd_w_en_in  in  1  instruction writes rd
- alu_result  in  32  ALU result, or effective address for load/store
- alu_store_data  in  32  rs2 value for stores
- alu_is_load  in  1  load instruction
- alu_is_store  in  1  store instruction
- alu_funct3  in  3  load/store size and sign
- mem_stall  out  1  stage 4 cannot accept; upstream holds
- mem_en  out  1  stage 4 valid
- s4_rd  out  5  stage-4 rd
- s4_rd_w_en  out  1  stage-4 writes rd
- s4_rd_valid  out  1  stage-4 data is final (low for loads)
- s4_rd_data  out  32  stage-4 ALU result
- writeback_en  out  1  stage 5 valid
- s5_rd  out  5  stage-5 rd (also regfile write address)
- s5_rd_w_en  out  1  regfile write enable
- writeback_rd_data  out  32  stage-5 data (also regfile write data)
- dmem_req  out  1  bus request
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ack  in  1  bus completes this cycle
- dmem_rdata  in  32  read word, valid with ack

Behaviour:
- Reset: every out is 0; FSM = S_EMPTY.
- FSM:
  - S_EMPTY: stage 4 holds nothing.
  - S_ALU: stage 4 holds a non-memory instruction.
  - S_MEM: stage 4 holds a load/store awaiting ack.
- Accept: stage 4 loads when alu_en && !mem_stall; next state is S_MEM if is_load|is_store, else S_ALU.
- No incoming instruction: S_ALU, or S_MEM with ack, goes to S_EMPTY.
- S_ALU always advances to stage 5 next edge.
- S_MEM:
  - dmem_req = 1 combinationally, held stable until ack; zero-wait ack in the entry cycle is legal.
  - ack: instruction advances next edge.
  - no ack: mem_stall=1, stage 5 receives a bubble (writeback_en=0).
- mem_stall = (state==S_MEM) && !dmem_ack.
- s4_rd_valid = !is_load for the held instruction; s4 outputs reflect the stage-4 register.
- Stage 5 has single-cycle occupancy, never stalls; writeback_en high exactly one cycle per retired instruction.
- s5_rd_w_en = rd_w_en && rd!=0 && writeback_en.
- Stores: s5_rd_w_en=0 but writeback_en=1.
- Latency: ALU op accepted at edge N is in stage 5 during N+1 and written at edge N+2. A load acked in cycle k is in stage 5 in cycle k+1.
- Load formatting, byte lane addr[1:0]:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half at addr[1]
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - others: word
- Store formatting:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0]
  - SH: wdata={2{h}}, wstrb=4'b0011<<{addr[1],1'b0}
  - SW: wstrb=4'b1111
- Misaligned addresses are truncated when the macro is off.
- Reset mid-S_MEM: dmem_req drops immediately (async). The bus is required to tolerate an abandoned request; the instruction is lost.
- Back-to-back: in the ack cycle a new instruction is accepted (mem_stall=0) while the load moves to stage 5.

Optional Feature:
- MEM_MISALIGN_TRAP_EN
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, asserts no dmem_req.
  - The instruction retires next edge with s5_rd_w_en=0.
  - Adds output mem_misaligned (1 bit), pulsed 1 cycle alongside writeback_en, and output mem_bad_addr (32 bits), which holds the address.
- Undefined: no port, silent truncation.

Decomposition:
- rv32i_header/package:
  - funct3 load/store encodings (LB..LHU, SB..SW)
  - ZERO_REG_ADDR
  - FSM state enum {S_EMPTY,S_ALU,S_MEM}
- Sub-module lsu_align: combinational load extract/sign-extend and store replicate/strobe, reused by later cache work.

Test Plan:
- ADD x5=0x1234 with alu_en one cycle → mem_en next cycle, s4_rd=5, s4_rd_valid=1; following cycle writeback_en=1, s5_rd_w_en=1, data 0x1234.
- LW x6 @0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - dmem_req held 3 cycles, dmem_addr=0x100
  - mem_stall=1 for 2 cycles, then 0 in the ack cycle
  - s4_rd_valid=0 throughout
  - next cycle writeback 0xDEADBEEF
- LB @0x103, rdata 0x80FF_FF_FF → 0xFFFFFF80; LBU same → 0x00000080; LHU @0x102 → 0x000080FF.
- SB 0xAB @0x201, zero-wait ack → wdata=0xABABABAB, wstrb=0010, dmem_we=1, s5_rd_w_en=0, writeback_en=1.
- rst asserted in S_MEM → dmem_req, mem_en, writeback_en go 0 same cycle; after release an ADD proceeds normally.
- With MEM_MISALIGN_TRAP_EN, LW @0x102 → no dmem_req, mem_misaligned=1 with writeback_en, mem_bad_addr=0x102, no regfile write.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared encodings, state enum and helpers for the mem/writeback stages
package mem_wb_stage_pkg;

  localparam logic [4:0] ZERO_REG_ADDR = 5'd0;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ALU   = 2'd1,
    S_MEM   = 2'd2
  } mem_state_e;

  // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
  // The low two funct3 bits give the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// rtl/mem_wb_stage_lsu_align.sv - combinational load extract/extend and store replicate/strobe
module lsu_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte/half out of the read word, then extend per funct3
  always_comb begin
    lane_byte = rdata[7:0];
    case (addr_lo)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, lane_byte};
      F3_LHU:  load_data = {16'd0, lane_half};
      default: load_data = rdata;
    endcase
  end

  // Replicate store data across all lanes; strobes select the lanes actually written
  always_comb begin
    case (funct3)
      F3_SB: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      F3_SW: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I stage-4/5 pipeline registers, data bus master, forwarding sources (option: MEM_MISALIGN_TRAP_EN)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_en,
  input  logic [4:0]      alu_rd,
  input  logic            alu_rd_w_en_in,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_store_data,
  input  logic            alu_is_load,
  input  logic            alu_is_store,
  input  logic [2:0]      alu_funct3,
  output logic            mem_stall,
  output logic            mem_en,
  output logic [4:0]      s4_rd,
  output logic            s4_rd_w_en,
  output logic            s4_rd_valid,
  output logic [XLEN-1:0] s4_rd_data,
  output logic            writeback_en,
  output logic [4:0]      s5_rd,
  output logic            s5_rd_w_en,
  output logic [XLEN-1:0] writeback_rd_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            mem_misaligned,
  output logic [XLEN-1:0] mem_bad_addr
`endif
);

  mem_state_e state, state_nxt;

  logic [4:0]      s4_rd_q;
  logic            s4_w_en_q;
  logic            s4_load_q;
  logic            s4_store_q;
  logic [2:0]      s4_f3_q;
  logic [XLEN-1:0] s4_result_q;
  logic [XLEN-1:0] s4_sdata_q;

  logic            s5_w_en_q;
  logic            wb_en_q;
  logic [4:0]      s5_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            s4_misal;
  logic            in_mem;
  logic            bus_active;
  logic            mem_done;
  logic            accept;
  logic            retire;

  logic [31:0]     load_data;
  logic [31:0]     align_wdata;
  logic [3:0]      align_wstrb;

`ifdef MEM_MISALIGN_TRAP_EN
  assign s4_misal = (s4_load_q || s4_store_q) && is_misaligned(s4_f3_q, s4_result_q[1:0]);
`else
  assign s4_misal = 1'b0;
`endif

  // A misaligned access never reaches the bus and completes without an ack
  assign in_mem     = (state == S_MEM);
  assign bus_active = in_mem && !s4_misal;
  assign mem_done   = in_mem && (s4_misal || dmem_ack);
  assign mem_stall  = in_mem && !mem_done;
  assign accept     = alu_en && !mem_stall;
  assign retire     = (state == S_ALU) || mem_done;

  lsu_align u_lsu_align (
    .funct3     (s4_f3_q),
    .addr_lo    (s4_result_q[1:0]),
    .rdata      (dmem_rdata),
    .store_data (s4_sdata_q),
    .load_data  (load_data),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb)
  );

  // Stage-4 occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next state: a new instruction wins; otherwise drain once stage 4 retires
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (alu_is_load || alu_is_store) ? S_MEM : S_ALU;
    end else if (retire) begin
      state_nxt = S_EMPTY;
    end
  end

  // Stage-4 pipeline register, loaded only on accept so it holds during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s4_rd_q     <= '0;
      s4_w_en_q   <= 1'b0;
      s4_load_q   <= 1'b0;
      s4_store_q  <= 1'b0;
      s4_f3_q     <= '0;
      s4_result_q <= '0;
      s4_sdata_q  <= '0;
    end else if (accept) begin
      s4_rd_q     <= alu_rd;
      s4_w_en_q   <= alu_rd_w_en_in;
      s4_load_q   <= alu_is_load;
      s4_store_q  <= alu_is_store;
      s4_f3_q     <= alu_funct3;
      s4_result_q <= alu_result;
      s4_sdata_q  <= alu_store_data;
    end
  end

  // Stage-5 register: single-cycle occupancy, a bubble whenever stage 4 does not retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      s5_w_en_q <= 1'b0;
      s5_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= retire;
      if (retire) begin
        s5_rd_q   <= s4_rd_q;
        s5_w_en_q <= s4_w_en_q && !s4_store_q && !s4_misal && (s4_rd_q != ZERO_REG_ADDR);
        wb_data_q <= s4_load_q ? load_data : s4_result_q;
      end else begin
        s5_w_en_q <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Trap flag pulses with the retiring instruction; the faulting address is kept until the next trap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_misaligned <= 1'b0;
      mem_bad_addr   <= '0;
    end else begin
      mem_misaligned <= retire && s4_misal;
      if (retire && s4_misal) mem_bad_addr <= s4_result_q;
    end
  end
`endif

  assign mem_en      = (state != S_EMPTY);
  assign s4_rd       = s4_rd_q;
  assign s4_rd_w_en  = mem_en && s4_w_en_q && !s4_store_q;
  assign s4_rd_valid = mem_en && !s4_load_q;
  assign s4_rd_data  = s4_result_q;

  assign writeback_en      = wb_en_q;
  assign s5_rd             = s5_rd_q;
  assign s5_rd_w_en        = s5_w_en_q;
  assign writeback_rd_data = wb_data_q;

  assign dmem_req   = bus_active;
  assign dmem_we    = bus_active && s4_store_q;
  assign dmem_addr  = bus_active ? {s4_result_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = (bus_active && s4_store_q) ? align_wdata : '0;
  assign dmem_wstrb = (bus_active && s4_store_q) ? align_wstrb : 4'b0000;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage (optionally with MEM_MISALIGN_TRAP_EN)
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_en;
  logic [4:0]  alu_rd;
  logic        alu_rd_w_en_in;
  logic [31:0] alu_result;
  logic [31:0] alu_store_data;
  logic        alu_is_load;
  logic        alu_is_store;
  logic [2:0]  alu_funct3;
  logic        mem_stall;
  logic        mem_en;
  logic [4:0]  s4_rd;
  logic        s4_rd_w_en;
  logic        s4_rd_valid;
  logic [31:0] s4_rd_data;
  logic        writeback_en;
  logic [4:0]  s5_rd;
  logic        s5_rd_w_en;
  logic [31:0] writeback_rd_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misaligned;
  logic [31:0] mem_bad_addr;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        w_en;
    logic [31:0] data;
    logic        chk_data;
  } wb_t;

  wb_t sb_q[$];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .alu_en            (alu_en),
    .alu_rd            (alu_rd),
    .alu_rd_w_en_in    (alu_rd_w_en_in),
    .alu_result        (alu_result),
    .alu_store_data    (alu_store_data),
    .alu_is_load       (alu_is_load),
    .alu_is_store      (alu_is_store),
    .alu_funct3        (alu_funct3),
    .mem_stall         (mem_stall),
    .mem_en            (mem_en),
    .s4_rd             (s4_rd),
    .s4_rd_w_en        (s4_rd_w_en),
    .s4_rd_valid       (s4_rd_valid),
    .s4_rd_data        (s4_rd_data),
    .writeback_en      (writeback_en),
    .s5_rd             (s5_rd),
    .s5_rd_w_en        (s5_rd_w_en),
    .writeback_rd_data (writeback_rd_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_misaligned    (mem_misaligned),
    .mem_bad_addr      (mem_bad_addr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic w_en, input logic [31:0] res,
                       input logic [31:0] sdata, input logic ld, input logic st,
                       input logic [2:0] f3);
    alu_en         = 1'b1;
    alu_rd         = rd;
    alu_rd_w_en_in = w_en;
    alu_result     = res;
    alu_store_data = sdata;
    alu_is_load    = ld;
    alu_is_store   = st;
    alu_funct3     = f3;
  endtask

  task automatic idle();
    alu_en         = 1'b0;
    alu_rd         = 5'd0;
    alu_rd_w_en_in = 1'b0;
    alu_result     = 32'd0;
    alu_store_data = 32'd0;
    alu_is_load    = 1'b0;
    alu_is_store   = 1'b0;
    alu_funct3     = 3'd0;
  endtask

  task automatic push(input logic [4:0] rd, input logic w_en, input logic [31:0] data,
                      input logic chk_data);
    wb_t e;
    e.rd = rd; e.w_en = w_en; e.data = data; e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  // Load with a zero-wait ack; expected writeback goes to the scoreboard
  task automatic load_zw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
    @(posedge clk); #1;
    issue(rd, 1'b1, addr, 32'd0, 1'b1, 1'b0, f3);
    push(rd, 1'b1, exp, 1'b1);
    @(posedge clk); #1;
    idle();
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  // Scoreboard: every writeback pops one expected entry
  always @(negedge clk) begin
    if (!rst && writeback_en) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", {31'd0, writeback_en}, 32'd0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, s5_rd}, {27'd0, e.rd});
        chk("wb_w_en", {31'd0, s5_rd_w_en}, {31'd0, e.w_en});
        if (e.chk_data) chk("wb_data", writeback_rd_data, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_wb_en", {31'd0, writeback_en}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_s4_valid", {31'd0, s4_rd_valid}, 32'd0);
    chk("rst_wb_data", writeback_rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD x5 = 0x1234
    @(posedge clk); #1;
    issue(5'd5, 1'b1, 32'h1234, 32'd0, 1'b0, 1'b0, 3'd0);
    push(5'd5, 1'b1, 32'h1234, 1'b1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("add_mem_en", {31'd0, mem_en}, 32'd1);
    chk("add_s4_rd", {27'd0, s4_rd}, 32'd5);
    chk("add_s4_valid", {31'd0, s4_rd_valid}, 32'd1);
    chk("add_s4_data", s4_rd_data, 32'h1234);
    chk("add_wb_early", {31'd0, writeback_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("add_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("add_mem_en_drain", {31'd0, mem_en}, 32'd0);

    // LW x6 @0x100, ack in the third request cycle
    @(posedge clk); #1;
    issue(5'd6, 1'b1, 32'h100, 32'd0, 1'b1, 1'b0, 3'b010);
    push(5'd6, 1'b1, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lw_req", {31'd0, dmem_req}, 32'd1);
      chk("lw_addr", dmem_addr, 32'h100);
      chk("lw_we", {31'd0, dmem_we}, 32'd0);
      chk("lw_stall", {31'd0, mem_stall}, 32'd1);
      chk("lw_s4_valid", {31'd0, s4_rd_valid}, 32'd0);
      chk("lw_bubble", {31'd0, writeback_en}, 32'd0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("lw_ack_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_ack_stall", {31'd0, mem_stall}, 32'd0);
    chk("lw_ack_s4_valid", {31'd0, s4_rd_valid}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    chk("lw_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("lw_wb_data", writeback_rd_data, 32'hDEADBEEF);
    chk("lw_req_drop", {31'd0, dmem_req}, 32'd0);

    // Sub-word load extraction
    load_zw("lb",  3'b000, 32'h103, 32'h80FFFFFF, 5'd7, 32'hFFFFFF80);
    load_zw("lbu", 3'b100, 32'h103, 32'h80FFFFFF, 5'd8, 32'h00000080);
    load_zw("lhu", 3'b101, 32'h102, 32'h80FFFFFF, 5'd9, 32'h000080FF);
    load_zw("lh",  3'b001, 32'h102, 32'h80FFFFFF, 5'd9, 32'hFFFF80FF);
    load_zw("lb0", 3'b000, 32'h100, 32'h0000007F, 5'd9, 32'h0000007F);

    // SB 0xAB @0x201, zero-wait ack
    @(posedge clk); #1;
    issue(5'd9, 1'b1, 32'h201, 32'h123456AB, 1'b0, 1'b1, 3'b000);
    push(5'd9, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    idle();
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
    chk("sb_addr", dmem_addr, 32'h200);
    chk("sb_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("sb_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("sb_no_write", {31'd0, s5_rd_w_en}, 32'd0);

    // SH 0xCAFE @0x206
    @(posedge clk); #1;
    issue(5'd0, 1'b0, 32'h206, 32'h0000CAFE, 1'b0, 1'b1, 3'b001);
    push(5'd0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    idle();
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sh_wdata", dmem_wdata, 32'hCAFECAFE);
    chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    // Back-to-back: ADD accepted in the load's ack cycle
    @(posedge clk); #1;
    issue(5'd11, 1'b1, 32'h300, 32'd0, 1'b1, 1'b0, 3'b010);
    push(5'd11, 1'b1, 32'h11112222, 1'b1);
    @(posedge clk); #1;
    issue(5'd12, 1'b1, 32'h55, 32'd0, 1'b0, 1'b0, 3'd0);
    push(5'd12, 1'b1, 32'h55, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11112222;
    @(negedge clk);
    chk("b2b_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    idle();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    chk("b2b_wb_load", writeback_rd_data, 32'h11112222);
    chk("b2b_s4_rd", {27'd0, s4_rd}, 32'd12);
    chk("b2b_s4_valid", {31'd0, s4_rd_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_wb_add", writeback_rd_data, 32'h55);

    // Write to x0 is suppressed at the register file
    @(posedge clk); #1;
    issue(5'd0, 1'b1, 32'h77, 32'd0, 1'b0, 1'b0, 3'd0);
    push(5'd0, 1'b0, 32'h77, 1'b1);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    @(negedge clk);
    chk("x0_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("x0_no_write", {31'd0, s5_rd_w_en}, 32'd0);

    // Reset while a load waits for ack: abandoned, no writeback
    @(posedge clk); #1;
    issue(5'd13, 1'b1, 32'h400, 32'd0, 1'b1, 1'b0, 3'b010);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("rmid_req_before", {31'd0, dmem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rmid_req", {31'd0, dmem_req}, 32'd0);
    chk("rmid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rmid_wb_en", {31'd0, writeback_en}, 32'd0);
    chk("rmid_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(5'd14, 1'b1, 32'hA5A5, 32'd0, 1'b0, 1'b0, 3'd0);
    push(5'd14, 1'b1, 32'hA5A5, 1'b1);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rpost_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("rpost_w_en", {31'd0, s5_rd_w_en}, 32'd1);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW traps without touching the bus
    @(posedge clk); #1;
    issue(5'd15, 1'b1, 32'h102, 32'd0, 1'b1, 1'b0, 3'b010);
    push(5'd15, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_flag", {31'd0, mem_misaligned}, 32'd1);
    chk("mis_wb_en", {31'd0, writeback_en}, 32'd1);
    chk("mis_bad_addr", mem_bad_addr, 32'h102);
    chk("mis_no_write", {31'd0, s5_rd_w_en}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_flag_pulse", {31'd0, mem_misaligned}, 32'd0);
    chk("mis_bad_hold", mem_bad_addr, 32'h102);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
